// File: rtl/adder8_chain_ctrl.sv
// Multi-precision add/subtract sequencer around an external 8-bit ripple adder.
// Two-stage pipeline: operand register drives the adder, output register captures its result.
module adder8_chain_ctrl #(
    parameter int MAX_WORDS = 4,
    parameter int CW        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_cin,
    input  logic       in_sub,
    input  logic       in_last,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_c,
    input  logic [7:0] add_s,
    input  logic       add_cout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_s,
    output logic       out_last,
    output logic       out_cout,
    output logic       out_err
);

    logic          r_s1_valid;
    logic [7:0]    r_s1_a;
    logic [7:0]    r_s1_b;
    logic          r_s1_first;
    logic          r_s1_last;
    logic          r_s1_err;
    logic          r_s1_cin;
    logic          r_carry;
    logic          r_sub;
    logic          r_first;
    logic [CW-1:0] r_count;

    logic          r_out_valid;
    logic [7:0]    r_out_s;
    logic          r_out_last;
    logic          r_out_cout;
    logic          r_out_err;

    logic          w_adv2;
    logic          w_in_ready;
    logic          w_accept;
    logic [CW-1:0] w_pos;
    logic          w_max;
    logic          w_term;

    assign w_adv2     = r_s1_valid & (~r_out_valid | out_ready);
    assign w_in_ready = ~r_s1_valid | w_adv2;
    assign w_accept   = in_valid & w_in_ready;

    // 1-based position of the byte being accepted within its packet
    assign w_pos  = r_first ? CW'(1) : r_count + CW'(1);
    assign w_max  = (w_pos == CW'(MAX_WORDS));
    assign w_term = in_last | w_max;

    // sub_reg always describes the packet of the byte currently in stage 1
    assign add_a = r_s1_a;
    assign add_b = r_sub ? ~r_s1_b : r_s1_b;
    assign add_c = r_s1_first ? r_s1_cin : r_carry;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_s     = r_out_s;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;
    assign out_err   = r_out_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_cin    <= 1'b0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_first     <= 1'b1;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_first <= r_first;
                r_s1_last  <= w_term;
                r_s1_err   <= w_max & ~in_last;
                r_s1_cin   <= in_cin | in_sub;
                r_count    <= w_pos;
                r_first    <= w_term;
                if (r_first)
                    r_sub <= in_sub;
            end else if (w_adv2) begin
                r_s1_valid <= 1'b0;
            end

            if (w_adv2) begin
                r_carry     <= add_cout;
                r_out_valid <= 1'b1;
                r_out_s     <= add_s;
                r_out_last  <= r_s1_last;
                r_out_cout  <= r_s1_last & add_cout;
                r_out_err   <= r_s1_err;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
